// File: rtl/instr_decode_seq.sv
// Fetch/execute sequencer, instruction register, opcode decoder and G flag for the datapath control.
// Optional ILLEGAL_TRAP_EN: adds a sticky `illegal` output and halts on undecoded opcodes.
module instr_decode_seq #(
  parameter int unsigned MEM_WAIT = 0,
  parameter logic [7:0]  IR_RST   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ir_bus,
  input  logic       sm_en,
  input  logic       gf_en,
  input  logic       g_in,
  output logic [7:0] ir,
  output logic       sm,
  output logic       mova,
  output logic       movb,
  output logic       movc,
  output logic       movd,
  output logic       add,
  output logic       sub,
  output logic       jmp,
  output logic       jg,
  output logic       in1,
  output logic       out1,
  output logic       movi,
  output logic       halt,
  output logic       g
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic       illegal
`endif
);

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    EXEC   = 2'b01,
    HALTED = 2'b10
  } state_t;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  state_t     state_q, state_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] ir_q, ir_d;
  logic       g_q;
  logic       stop_exec;

  logic [3:0] op;
  logic [1:0] dr;
  logic [1:0] sr;

  assign op = ir_q[7:4];
  assign dr = ir_q[3:2];
  assign sr = ir_q[1:0];

  // Strobes depend only on ir and state, so a stall naturally holds them.
  always_comb begin
    mova = 1'b0;
    movb = 1'b0;
    movc = 1'b0;
    movd = 1'b0;
    add  = 1'b0;
    sub  = 1'b0;
    jmp  = 1'b0;
    jg   = 1'b0;
    in1  = 1'b0;
    out1 = 1'b0;
    movi = 1'b0;
    halt = 1'b0;
    if (state_q == EXEC) begin
      case (op)
        4'b1111: begin
          if (dr == 2'b11)      movb = 1'b1;
          else if (sr == 2'b11) movc = 1'b1;
          else                  mova = 1'b1;
        end
        4'b1001: add  = 1'b1;
        4'b0110: sub  = 1'b1;
        4'b0010: in1  = 1'b1;
        4'b0100: out1 = 1'b1;
        4'b0101: movd = 1'b1;
        4'b0111: movi = 1'b1;
        4'b1000: jmp  = 1'b1;
        4'b1100: jg   = 1'b1;
        4'b1010: halt = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
  logic known_op;

  always_comb begin
    known_op = 1'b0;
    case (op)
      4'b1111, 4'b1001, 4'b0110, 4'b0010, 4'b0100, 4'b0101,
      4'b0111, 4'b1000, 4'b1100, 4'b1010: known_op = 1'b1;
      default: known_op = 1'b0;
    endcase
  end

  assign stop_exec = halt | ~known_op;

  always_comb begin
    illegal_d = illegal_q;
    if (sm_en && (state_q == EXEC) && !known_op) illegal_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) illegal_q <= 1'b0;
    else      illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`else
  assign stop_exec = halt;
`endif

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ir_d       = ir_q;
    if (sm_en) begin
      case (state_q)
        FETCH: begin
          if (wait_cnt_q == WAIT_LAST) begin
            ir_d       = ir_bus;
            wait_cnt_d = 3'd0;
            state_d    = EXEC;
          end else begin
            wait_cnt_d = wait_cnt_q + 3'd1;
          end
        end
        EXEC:    state_d = stop_exec ? HALTED : FETCH;
        HALTED:  state_d = HALTED;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      wait_cnt_q <= 3'd0;
      ir_q       <= IR_RST;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ir_q       <= ir_d;
    end
  end

  // G flag ignores state and sm_en: the ALU may write it at any time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       g_q <= 1'b0;
    else if (gf_en) g_q <= g_in;
  end

  assign ir = ir_q;
  assign sm = (state_q != FETCH);
  assign g  = g_q;

endmodule

// File: tb/tb_instr_decode_seq.sv
// Directed bench: instance A uses MEM_WAIT=0, instance B uses MEM_WAIT=2; strobes packed mova..halt (MSB..LSB).
module tb_instr_decode_seq;

  localparam logic [11:0] S_NONE = 12'h000;
  localparam logic [11:0] S_MOVA = 12'h800;
  localparam logic [11:0] S_MOVB = 12'h400;
  localparam logic [11:0] S_MOVC = 12'h200;
  localparam logic [11:0] S_MOVD = 12'h100;
  localparam logic [11:0] S_ADD  = 12'h080;
  localparam logic [11:0] S_SUB  = 12'h040;
  localparam logic [11:0] S_JMP  = 12'h020;
  localparam logic [11:0] S_JG   = 12'h010;
  localparam logic [11:0] S_IN1  = 12'h008;
  localparam logic [11:0] S_OUT1 = 12'h004;
  localparam logic [11:0] S_MOVI = 12'h002;
  localparam logic [11:0] S_HALT = 12'h001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] ir_bus_a, ir_bus_b;
  logic       sm_en_a, sm_en_b, gf_en_a, gf_en_b, g_in_a, g_in_b;

  logic [7:0] ir_a, ir_b;
  logic       sm_a, sm_b, g_a, g_b;
  logic       mova_a, movb_a, movc_a, movd_a, add_a, sub_a, jmp_a, jg_a, in1_a, out1_a, movi_a, halt_a;
  logic       mova_b, movb_b, movc_b, movd_b, add_b, sub_b, jmp_b, jg_b, in1_b, out1_b, movi_b, halt_b;
  logic [11:0] strobes_a, strobes_b;
`ifdef ILLEGAL_TRAP_EN
  logic       illegal_a, illegal_b;
`endif

  assign strobes_a = {mova_a, movb_a, movc_a, movd_a, add_a, sub_a, jmp_a, jg_a, in1_a, out1_a, movi_a, halt_a};
  assign strobes_b = {mova_b, movb_b, movc_b, movd_b, add_b, sub_b, jmp_b, jg_b, in1_b, out1_b, movi_b, halt_b};

  instr_decode_seq #(.MEM_WAIT(0), .IR_RST(8'h00)) u_dut_a (
    .clk(clk), .rst(rst), .ir_bus(ir_bus_a), .sm_en(sm_en_a), .gf_en(gf_en_a), .g_in(g_in_a),
    .ir(ir_a), .sm(sm_a), .mova(mova_a), .movb(movb_a), .movc(movc_a), .movd(movd_a),
    .add(add_a), .sub(sub_a), .jmp(jmp_a), .jg(jg_a), .in1(in1_a), .out1(out1_a),
    .movi(movi_a), .halt(halt_a), .g(g_a)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal_a)
`endif
  );

  instr_decode_seq #(.MEM_WAIT(2), .IR_RST(8'h00)) u_dut_b (
    .clk(clk), .rst(rst), .ir_bus(ir_bus_b), .sm_en(sm_en_b), .gf_en(gf_en_b), .g_in(g_in_b),
    .ir(ir_b), .sm(sm_b), .mova(mova_b), .movb(movb_b), .movc(movc_b), .movd(movd_b),
    .add(add_b), .sub(sub_b), .jmp(jmp_b), .jg(jg_b), .in1(in1_b), .out1(out1_b),
    .movi(movi_b), .halt(halt_b), .g(g_b)
`ifdef ILLEGAL_TRAP_EN
    , .illegal(illegal_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full MEM_WAIT=2 instruction on instance B, starting from FETCH with wait_cnt=0.
  task automatic fetch_exec_b(input logic [7:0] opc, input logic [11:0] exp_s);
    ir_bus_b = opc;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("b_fetch_sm", sm_b, 1'b0);
      check("b_fetch_strobes", strobes_b, S_NONE);
    end
    tick();
    check("b_exec_sm", sm_b, 1'b1);
    check("b_exec_ir", ir_b, opc);
    check("b_exec_strobes", strobes_b, exp_s);
    tick();
    check("b_refetch_sm", sm_b, 1'b0);
    check("b_refetch_strobes", strobes_b, S_NONE);
    $display("fetch_exec B ir=%h strobes=%h", opc, exp_s);
  endtask

  logic [7:0]  opc_tbl [12];
  logic [11:0] exp_tbl [12];

  initial begin
    opc_tbl = '{8'hF4, 8'hFC, 8'hF7, 8'hFF, 8'h9A, 8'h6C, 8'h23, 8'h41, 8'h5B, 8'h72, 8'h8E, 8'hC5};
    exp_tbl = '{S_MOVA, S_MOVB, S_MOVC, S_MOVB, S_ADD, S_SUB, S_IN1, S_OUT1, S_MOVD, S_MOVI, S_JMP, S_JG};

    rst = 1'b0;
    ir_bus_a = 8'hFF; ir_bus_b = 8'hFF;
    sm_en_a = 1'b1; sm_en_b = 1'b1;
    gf_en_a = 1'b1; g_in_a = 1'b1;
    gf_en_b = 1'b0; g_in_b = 1'b0;

    // Reset held while the bus toggles and the G flag is being written.
    repeat (4) begin
      tick();
      ir_bus_a = ~ir_bus_a;
      ir_bus_b = ~ir_bus_b;
    end
    check("rst_ir_a", ir_a, 8'h00);
    check("rst_sm_a", sm_a, 1'b0);
    check("rst_g_a", g_a, 1'b0);
    check("rst_strobes_a", strobes_a, S_NONE);
    check("rst_ir_b", ir_b, 8'h00);
    check("rst_sm_b", sm_b, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    check("rst_illegal_a", illegal_a, 1'b0);
`endif

    gf_en_a = 1'b0; g_in_a = 1'b0;
    ir_bus_a = 8'h96;
    sm_en_b = 1'b0;
    rst = 1'b1;

    // Instance A: single-cycle fetch.
    tick();
    check("a_add_ir", ir_a, 8'h96);
    check("a_add_sm", sm_a, 1'b1);
    check("a_add_strobes", strobes_a, S_ADD);
    $display("fetch_exec A ir=96");
    ir_bus_a = 8'hC0;
    tick();
    check("a_refetch_sm", sm_a, 1'b0);
    check("a_refetch_strobes", strobes_a, S_NONE);
    check("a_refetch_ir", ir_a, 8'h96);
    tick();
    check("a_jg_ir", ir_a, 8'hC0);
    check("a_jg_strobes", strobes_a, S_JG);

    // Stall in EXEC.
    sm_en_a = 1'b0;
    ir_bus_a = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("a_stall_sm", sm_a, 1'b1);
      check("a_stall_strobes", strobes_a, S_JG);
      check("a_stall_ir", ir_a, 8'hC0);
    end
    $display("stall A 4 cycles in EXEC ir=C0");
    sm_en_a = 1'b1;
    ir_bus_a = 8'h61;
    tick();
    check("a_resume_sm", sm_a, 1'b0);
    tick();
    check("a_sub_strobes", strobes_a, S_SUB);
    check("a_sub_g_before", g_a, 1'b0);
    gf_en_a = 1'b1; g_in_a = 1'b1;
    tick();
    check("a_g_set", g_a, 1'b1);
    check("a_g_set_sm", sm_a, 1'b0);
    gf_en_a = 1'b0; g_in_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("a_g_hold", g_a, 1'b1);
      check("a_g_hold_sm", sm_a, (i % 2 == 0) ? 1'b1 : 1'b0);
    end
    $display("g flag A held over 10 fetch/exec pairs");

    // HALT, with a simultaneous G flag write.
    ir_bus_a = 8'hA0;
    tick();
    check("a_halt_ir", ir_a, 8'hA0);
    check("a_halt_strobes", strobes_a, S_HALT);
    gf_en_a = 1'b1; g_in_a = 1'b0;
    tick();
    check("a_halted_g", g_a, 1'b0);
    gf_en_a = 1'b0;
    ir_bus_a = 8'h96;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("a_halted_sm", sm_a, 1'b1);
      check("a_halted_strobes", strobes_a, S_NONE);
      check("a_halted_ir", ir_a, 8'hA0);
    end
    $display("halt A frozen 20 cycles ir=A0");

    // Asynchronous reset between clock edges.
    rst = 1'b0;
    #2;
    check("a_async_rst_ir", ir_a, 8'h00);
    check("a_async_rst_sm", sm_a, 1'b0);
    check("a_async_rst_strobes", strobes_a, S_NONE);
    tick();
    sm_en_a = 1'b0;
    sm_en_b = 1'b1;
    rst = 1'b1;

    // Instance B: three-cycle fetch, with a stall in the middle of the wait count.
    ir_bus_b = 8'hF4;
    tick();
    check("b_stallfetch_sm0", sm_b, 1'b0);
    sm_en_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_stallfetch_sm", sm_b, 1'b0);
      check("b_stallfetch_ir", ir_b, 8'h00);
    end
    sm_en_b = 1'b1;
    tick();
    check("b_stallfetch_sm2", sm_b, 1'b0);
    check("b_stallfetch_ir2", ir_b, 8'h00);
    tick();
    check("b_stallfetch_exec_sm", sm_b, 1'b1);
    check("b_stallfetch_exec_strobes", strobes_b, S_MOVA);
    tick();
    check("b_stallfetch_back", sm_b, 1'b0);
    $display("fetch stall B ir=F4");

    for (int i = 0; i < 12; i++) fetch_exec_b(opc_tbl[i], exp_tbl[i]);
    check("b_g_untouched", g_b, 1'b0);
    check("a_parked_sm", sm_a, 1'b0);

    // Undecoded opcode 0x30.
    ir_bus_b = 8'h30;
    repeat (3) tick();
    check("b_undef_exec_sm", sm_b, 1'b1);
    check("b_undef_exec_strobes", strobes_b, S_NONE);
`ifdef ILLEGAL_TRAP_EN
    check("b_undef_illegal_pre", illegal_b, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_trap_sm", sm_b, 1'b1);
      check("b_trap_illegal", illegal_b, 1'b1);
      check("b_trap_strobes", strobes_b, S_NONE);
    end
    check("a_illegal_clear", illegal_a, 1'b0);
`else
    tick();
    check("b_nop_back_sm", sm_b, 1'b0);
    check("b_nop_back_strobes", strobes_b, S_NONE);
`endif
    $display("undecoded B ir=30");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
